// File: rtl/float_compare.sv
// float_compare: two-stage pipelined IEEE-754 comparison with sticky invalid flag
module float_compare #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [2:0]             in_op,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_z,
    output logic                   out_unordered,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear_flags,
    output logic                   invalid_flag
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic       s1_valid_q, s1_valid_d;
    logic [2:0] s1_op_q, s1_op_d;
    logic       s1_a_nan_q, s1_a_nan_d, s1_b_nan_q, s1_b_nan_d;
    logic       s1_snan_q, s1_snan_d;
    logic       s1_a_zero_q, s1_a_zero_d, s1_b_zero_q, s1_b_zero_d;
    logic       s1_a_sign_q, s1_a_sign_d, s1_b_sign_q, s1_b_sign_d;
    logic       s1_gt_q, s1_gt_d, s1_eq_q, s1_eq_d;
    logic       out_valid_q, out_valid_d;
    logic       out_z_q, out_z_d;
    logic       out_un_q, out_un_d;
    logic       out_inv_q, out_inv_d;
    logic       flag_q, flag_d;

    logic       a_nan, b_nan, a_snan, b_snan;
    logic       load1, adv2, load2;
    logic       unord, both_zero, eq, lt, gt, z, inv;

    // Stage 1: classify operands and compare magnitude fields as unsigned integers
    always_comb begin
        a_nan       = (&in_a[W-2:MAN_W]) & (|in_a[MAN_W-1:0]);
        b_nan       = (&in_b[W-2:MAN_W]) & (|in_b[MAN_W-1:0]);
        a_snan      = a_nan & ~in_a[MAN_W-1];
        b_snan      = b_nan & ~in_b[MAN_W-1];
        load1       = in_ready & in_valid;
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        s1_op_d     = load1 ? in_op : s1_op_q;
        s1_a_nan_d  = load1 ? a_nan : s1_a_nan_q;
        s1_b_nan_d  = load1 ? b_nan : s1_b_nan_q;
        s1_snan_d   = load1 ? (a_snan | b_snan) : s1_snan_q;
        s1_a_zero_d = load1 ? ~|in_a[W-2:0] : s1_a_zero_q;
        s1_b_zero_d = load1 ? ~|in_b[W-2:0] : s1_b_zero_q;
        s1_a_sign_d = load1 ? in_a[W-1] : s1_a_sign_q;
        s1_b_sign_d = load1 ? in_b[W-1] : s1_b_sign_q;
        s1_gt_d     = load1 ? (in_a[W-2:0] > in_b[W-2:0]) : s1_gt_q;
        s1_eq_d     = load1 ? (in_a[W-2:0] == in_b[W-2:0]) : s1_eq_q;
    end

    // Stage 2: resolve sign/magnitude into the selected predicate and invalid condition
    always_comb begin
        unord     = s1_a_nan_q | s1_b_nan_q;
        both_zero = s1_a_zero_q & s1_b_zero_q;
        eq        = both_zero | ((s1_a_sign_q == s1_b_sign_q) & s1_eq_q);
        lt        = ~both_zero & ((s1_a_sign_q & ~s1_b_sign_q)
                  | (~s1_a_sign_q & ~s1_b_sign_q & ~s1_gt_q & ~s1_eq_q)
                  | (s1_a_sign_q & s1_b_sign_q & s1_gt_q));
        gt        = ~eq & ~lt;
        z         = 1'b0;
        case (s1_op_q)
            3'd0:    z = ~unord & eq;
            3'd1:    z = unord | ~eq;
            3'd2:    z = ~unord & lt;
            3'd3:    z = ~unord & (lt | eq);
            3'd4:    z = ~unord & gt;
            3'd5:    z = ~unord & (gt | eq);
            3'd6:    z = unord;
            default: z = ~unord;
        endcase
        inv         = s1_snan_q | (unord & (s1_op_q >= 3'd2) & (s1_op_q <= 3'd5));
        adv2        = ~out_valid_q | out_ready;
        load2       = adv2 & s1_valid_q;
        in_ready    = ~s1_valid_q | adv2;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_z_d     = load2 ? z : out_z_q;
        out_un_d    = load2 ? unord : out_un_q;
        out_inv_d   = load2 ? inv : out_inv_q;
        flag_d      = (out_valid_q & out_ready & out_inv_q) | (flag_q & ~clear_flags);
    end

    // Pipeline and flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_nan_q  <= 1'b0;
            s1_b_nan_q  <= 1'b0;
            s1_snan_q   <= 1'b0;
            s1_a_zero_q <= 1'b0;
            s1_b_zero_q <= 1'b0;
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
            s1_gt_q     <= 1'b0;
            s1_eq_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= 1'b0;
            out_un_q    <= 1'b0;
            out_inv_q   <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_nan_q  <= s1_a_nan_d;
            s1_b_nan_q  <= s1_b_nan_d;
            s1_snan_q   <= s1_snan_d;
            s1_a_zero_q <= s1_a_zero_d;
            s1_b_zero_q <= s1_b_zero_d;
            s1_a_sign_q <= s1_a_sign_d;
            s1_b_sign_q <= s1_b_sign_d;
            s1_gt_q     <= s1_gt_d;
            s1_eq_q     <= s1_eq_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_un_q    <= out_un_d;
            out_inv_q   <= out_inv_d;
            flag_q      <= flag_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_z         = out_z_q;
    assign out_unordered = out_un_q;
    assign invalid_flag  = flag_q;
endmodule

// File: tb/tb_float_compare.sv
// tb_float_compare: directed vector checks of float_compare in binary64 and binary32 builds
module tb_float_compare;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic        z;
        logic        un;
        logic        inv;
    } vec_t;

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] NONE = 64'hBFF0000000000000;
    localparam logic [63:0] NTWO = 64'hC000000000000000;
    localparam logic [63:0] PZ   = 64'h0000000000000000;
    localparam logic [63:0] NZ   = 64'h8000000000000000;
    localparam logic [63:0] QN   = 64'h7FF8000000000000;
    localparam logic [63:0] SN   = 64'h7FF0000000000001;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] NINF = 64'hFFF0000000000000;
    localparam logic [63:0] MAXF = 64'h7FEFFFFFFFFFFFFF;
    localparam logic [63:0] SUB  = 64'h0000000000000001;
    localparam logic [63:0] NSUB = 64'h8000000000000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1, clear_flags = 1'b0;
    logic        in_ready, out_z, out_un, out_valid, invalid_flag;

    logic [31:0] s_a = '0, s_b = '0;
    logic [2:0]  s_op = '0;
    logic        s_in_valid = 1'b0, s_out_ready = 1'b1, s_clear = 1'b0;
    logic        s_in_ready, s_out_z, s_out_un, s_out_valid, s_flag;

    int total = 0, passed = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    float_compare dut (
        .clk(clk), .rst_n(rst_n), .in_a(a), .in_b(b), .in_op(op),
        .in_valid(in_valid), .in_ready(in_ready), .out_z(out_z),
        .out_unordered(out_un), .out_valid(out_valid), .out_ready(out_ready),
        .clear_flags(clear_flags), .invalid_flag(invalid_flag)
    );

    float_compare #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_a(s_a), .in_b(s_b), .in_op(s_op),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_z(s_out_z),
        .out_unordered(s_out_un), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .clear_flags(s_clear), .invalid_flag(s_flag)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk($sformatf("v%0d in_ready", idx), in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom);
        @(negedge clk);
        chk($sformatf("v%0d valid early", idx), out_valid, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d valid", idx), out_valid, 1'b1);
        chk($sformatf("v%0d z", idx), out_z, v.z);
        chk($sformatf("v%0d unordered", idx), out_un, v.un);
        @(negedge clk);
        chk($sformatf("v%0d invalid", idx), invalid_flag, v.inv);
        chk($sformatf("v%0d drained", idx), out_valid, 1'b0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk($sformatf("v%0d cleared", idx), invalid_flag, 1'b0);
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o,
                         input logic ez, input string name);
        @(negedge clk);
        s_a = x; s_b = y; s_op = o; s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({name, " valid"}, s_out_valid, 1'b1);
        chk({name, " z"}, s_out_z, ez);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, rcv, cyc, inflight;
        logic stalled, pz, pu, acc, done;
        tbl[0]  = '{ONE,  TWO,  3'd2, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{NZ,   PZ,   3'd0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{NZ,   PZ,   3'd2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{NZ,   PZ,   3'd5, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{QN,   ONE,  3'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{QN,   ONE,  3'd1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{QN,   ONE,  3'd2, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{SN,   PINF, 3'd6, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{SN,   PINF, 3'd0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{PINF, MAXF, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{NINF, NONE, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{SUB,  PZ,   3'd4, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{NTWO, NONE, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{NONE, NONE, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{ONE,  TWO,  3'd7, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{QN,   ONE,  3'd7, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{TWO,  TWO,  3'd1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{ONE,  TWO,  3'd5, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{NONE, ONE,  3'd4, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{QN,   QN,   3'd6, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{NSUB, PZ,   3'd2, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{ONE,  TWO,  3'd6, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_z", out_z, 1'b0);
        chk("reset out_unordered", out_un, 1'b0);
        chk("reset invalid_flag", invalid_flag, 1'b0);
        rst_n = 1'b1;
        #1 chk("ready after reset", in_ready, 1'b1);

        for (int i = 0; i < 22; i++) run_vec(tbl[i], i);

        // set wins over clear on the handshake cycle; flag not raised before handshake
        @(negedge clk);
        a = QN; b = ONE; op = 3'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("set/clear valid", out_valid, 1'b1);
        chk("flag before handshake", invalid_flag, 1'b0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("set wins over clear", invalid_flag, 1'b1);
        chk("flag sticky idle", invalid_flag, 1'b1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("flag cleared", invalid_flag, 1'b0);

        // back-to-back stream with random backpressure
        sent = 0; rcv = 0; cyc = 0; inflight = 0; stalled = 1'b0; pz = 1'b0; pu = 1'b0;
        while (rcv < 8 && cyc < 300) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 8);
            if (sent < 8) begin
                a = tbl[sent].a; b = tbl[sent].b; op = tbl[sent].op;
            end
            #1;
            chk("stream in_ready", in_ready, !(inflight == 2 && !out_ready));
            if (stalled) begin
                chk("hold valid", out_valid, 1'b1);
                chk("hold z", out_z, pz);
                chk("hold unordered", out_un, pu);
            end
            acc = in_valid & in_ready;
            done = out_valid & out_ready;
            if (done) begin
                chk($sformatf("stream r%0d z", rcv), out_z, tbl[rcv].z);
                chk($sformatf("stream r%0d unordered", rcv), out_un, tbl[rcv].un);
                rcv++;
            end
            stalled = out_valid & ~out_ready;
            pz = out_z; pu = out_un;
            inflight = inflight + int'(acc) - int'(done);
            if (acc) sent++;
            @(posedge clk);
            cyc++;
        end
        chk("stream all received", rcv == 8, 1'b1);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("stream no extra", out_valid, 1'b0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;

        // reset with both stages full discards everything
        out_ready = 1'b0;
        a = QN; b = ONE; op = 3'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 a = ONE; b = TWO; op = 3'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full out_valid", out_valid, 1'b1);
        chk("full in_ready low", in_ready, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid reset out_valid", out_valid, 1'b0);
        chk("mid reset invalid", invalid_flag, 1'b0);
        chk("mid reset in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid reset no output", out_valid, 1'b0);
        chk("mid reset flag stays 0", invalid_flag, 1'b0);

        // binary32 build
        run32(32'h00000001, 32'h80000001, 3'd4, 1'b1, "f32 sub GT");
        run32(32'h80000000, 32'h00000000, 3'd0, 1'b1, "f32 zero EQ");
        run32(32'h7F800000, 32'h7F7FFFFF, 3'd4, 1'b1, "f32 inf GT");
        run32(32'h7FC00000, 32'h3F800000, 3'd2, 1'b0, "f32 NaN LT");
        chk("f32 NaN unordered", s_out_un, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/float_compare.md
FLOAT_COMPARE -- requirements
Module: float_compare

Interface
REQ-001 SHALL provide parameter EXP_W, default 11, exponent field width.
REQ-002 SHALL provide parameter MAN_W, default 52, mantissa field width; operand width W = 1+EXP_W+MAN_W (default 64, binary64).
REQ-003 SHALL have ports:
- clk  input  1  sole clock, all state on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_a  input  W  operand a (sign MSB, then exponent, then mantissa).
- in_b  input  W  operand b.
- in_op  input  3  predicate select.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  block accepts input this cycle.
- out_z  output  1  predicate result.
- out_unordered  output  1  at least one operand is NaN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- clear_flags  input  1  clears invalid_flag.
- invalid_flag  output  1  sticky IEEE invalid-operation flag.

Function
REQ-004 SHALL encode in_op: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN (unordered), 7 ORD (ordered).
REQ-005 SHALL treat an operand as NaN when exponent is all ones and mantissa is nonzero; sNaN when mantissa MSB is 0, qNaN when it is 1.
REQ-006 SHALL compare a = b as true for bitwise-equal non-NaN operands and for +0 vs -0 in any sign combination.
REQ-007 SHALL order non-NaN operands numerically, including subnormals and +/-infinity, with no flushing of subnormals to zero.
REQ-008 SHALL make EQ, LT, LE, GT, GE false and NE true when either operand is NaN; UN = out_unordered; ORD = ~out_unordered.
REQ-009 SHALL compute a transaction's out_unordered independently of in_op.
REQ-010 SHALL raise invalid for a transaction when (op in LT, LE, GT, GE and any NaN) or (any op and any sNaN).
REQ-011 SHALL be a 2-stage pipeline: stage 1 registers classification (NaN/sNaN/zero flags, signs) and magnitude compare result (gt/eq of the W-1-bit magnitude fields); stage 2 registers out_z and out_unordered.
REQ-012 SHALL accept a transaction on a cycle with in_valid & in_ready; result presented exactly 2 cycles later when out_ready held high.
REQ-013 SHALL drive in_ready = ~s1_valid | ~out_valid | out_ready (stage 1 can advance or is empty).
REQ-014 SHALL advance stage 1 into stage 2 when ~out_valid | out_ready; complete on out_valid & out_ready.
REQ-015 SHALL hold out_z, out_unordered and out_valid stable while out_valid & ~out_ready.
REQ-016 SHALL sustain one transaction per cycle with out_ready high; no loss or duplication under any out_ready pattern.
REQ-017 SHALL preserve transaction order.
REQ-018 SHALL set invalid_flag the cycle after the stage-2 handshake of a transaction raising invalid; remains set until clear_flags.
REQ-019 SHALL clear invalid_flag on the cycle after clear_flags high; set wins over clear when both occur in the same cycle.
REQ-020 SHALL ignore in_a, in_b, in_op when in_valid is low.

Reset
REQ-021 SHALL, on rising clk with rst_n low, clear both stage valid bits, out_z, out_unordered and invalid_flag to 0.
REQ-022 SHALL discard in-flight transactions on reset mid-operation; no out_valid in the cycle after reset deasserts.
REQ-023 SHALL drive in_ready = 1 in the first cycle after reset release.

Verification
REQ-024 SHALL cover: a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), op LT, out_ready=1 -> out_z=1 at cycle+2, out_unordered=0, invalid_flag=0.
REQ-025 SHALL cover: a=0x8000000000000000, b=0x0000000000000000, ops EQ, LT, GE -> out_z = 1, 0, 1.
REQ-026 SHALL cover: a=0x7FF8000000000000 (qNaN), b=1.0; op EQ -> z=0, invalid_flag stays 0; op NE -> z=1; op LT -> z=0, out_unordered=1, invalid_flag=1; clear_flags -> 0.
REQ-027 SHALL cover: a=0x7FF0000000000001 (sNaN), b=0x7FF0000000000000 (+inf), op UN -> z=1, invalid_flag=1.
REQ-028 SHALL cover: 8 back-to-back transactions, out_ready random 50% -> all 8 results in order, outputs stable during stall, in_ready low only when both stages full and out_ready=0.
REQ-029 SHALL cover: rst_n low while both stages valid -> out_valid=0, invalid_flag=0 after reset; EXP_W=8, MAN_W=23 build: a=0x00000001, b=0x80000001, op GT -> z=1.
